// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI responder: FSM state encoding,
// synchroniser depth and the default idle/underrun word.
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_resp_state_t;

  localparam int SPI_SYNC_STAGES = 2;

  localparam logic [31:0] SPI_FILL_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/spi_responder_if.sv
// Host-side word streams of the SPI responder: TX words in, RX words out,
// each with a valid/ready handshake.
interface spi_responder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus one extra flop that
// turns the synchronised level into single-cycle rise/fall pulses.
module spi_sync_edge
  import spi_resp_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              delay_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= {STAGES{RST_VAL}};
      delay_reg <= RST_VAL;
    end else begin
      sync_reg  <= {sync_reg[STAGES-2:0], din};
      delay_reg <= sync_reg[STAGES-1];
    end
  end

  assign dout = sync_reg[STAGES-1];
  assign rise = sync_reg[STAGES-1] & ~delay_reg;
  assign fall = ~sync_reg[STAGES-1] & delay_reg;

endmodule

// File: rtl/spi_responder.sv
// Mode-0 MSB-first SPI target: oversamples SCLK/CS/MOSI in the clk domain and
// exchanges words with the host. Optional error flags under SPI_RESP_ERR_EN.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = SPI_FILL_DEFAULT[DATA_W-1:0]
) (
  input  logic clk,
  input  logic reset_n,
`ifdef SPI_RESP_ERR_EN
  input  logic err_clr,
  output logic rx_overrun,
  output logic tx_underrun,
`endif
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  spi_responder_if.slave host
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SPI_SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_s;

  spi_resp_state_t   state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rx_sh_reg, tx_sh_reg, hold_reg, rx_data_reg;
  logic              hold_full_reg, rx_valid_reg, miso_reg, armed_reg;
  logic [1:0]        settle_reg;

  logic              load_word, word_done, tx_accept;
  logic [DATA_W-1:0] load_value;

  // Only SCLK edges matter; its level is not used.
  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_sclk),
    .dout(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_sync_reg <= '0;
    else          mosi_sync_reg <= {mosi_sync_reg[SPI_SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync_reg[SPI_SYNC_STAGES-1];

  assign load_value = hold_full_reg ? hold_reg : FILL_WORD;
  assign tx_accept  = host.tx_valid && !hold_full_reg;

  always_comb begin
    state_next = state_reg;
    load_word  = 1'b0;
    word_done  = 1'b0;
    case (state_reg)
      IDLE:  if (cs_fall && armed_reg) state_next = LOAD;
      LOAD: begin
        load_word  = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: if (cnt_reg == CNT_W'(DATA_W)) begin
        word_done = 1'b1;
        load_word = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (cs_rise) begin
      state_next = IDLE;
      load_word  = 1'b0;
      word_done  = 1'b0;
    end
  end

  // After reset, a CS fall only counts once CS has been seen high through
  // freshly refilled synchroniser stages (not just their reset value).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rx_sh_reg     <= '0;
      tx_sh_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      miso_reg      <= 1'b0;
      armed_reg     <= 1'b0;
      settle_reg    <= 2'b00;
    end else begin
      state_reg  <= state_next;
      settle_reg <= {settle_reg[0], 1'b1};
      if (settle_reg[1] && cs_s) armed_reg <= 1'b1;

      if (load_word) hold_full_reg <= 1'b0;
      if (tx_accept) begin
        hold_full_reg <= 1'b1;
        hold_reg      <= host.tx_data;
      end

      if (cs_rise) begin
        cnt_reg  <= '0;
        miso_reg <= 1'b0;
      end else if (state_reg == LOAD) begin
        cnt_reg   <= '0;
        tx_sh_reg <= load_value << 1;
        miso_reg  <= load_value[DATA_W-1];
      end else if (state_reg == SHIFT) begin
        if (word_done) begin
          cnt_reg   <= '0;
          tx_sh_reg <= load_value;
        end else if (sclk_rise) begin
          rx_sh_reg <= {rx_sh_reg[DATA_W-2:0], mosi_s};
          cnt_reg   <= cnt_reg + CNT_W'(1);
        end else if (sclk_fall) begin
          miso_reg  <= tx_sh_reg[DATA_W-1];
          tx_sh_reg <= tx_sh_reg << 1;
        end
      end

      if (word_done) begin
        rx_data_reg  <= rx_sh_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && host.rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

`ifdef SPI_RESP_ERR_EN
  logic rx_overrun_reg, tx_underrun_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun_reg  <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      if (err_clr) begin
        rx_overrun_reg  <= 1'b0;
        tx_underrun_reg <= 1'b0;
      end
      if (word_done && rx_valid_reg)    rx_overrun_reg  <= 1'b1;
      if (load_word && !hold_full_reg)  tx_underrun_reg <= 1'b1;
    end
  end

  assign rx_overrun  = rx_overrun_reg;
  assign tx_underrun = tx_underrun_reg;
`endif

  assign spi_miso      = miso_reg;
  assign spi_miso_oe   = (state_reg != IDLE);
  assign busy          = ~cs_s;
  assign host.tx_ready = ~hold_full_reg;
  assign host.rx_data  = rx_data_reg;
  assign host.rx_valid = rx_valid_reg;

endmodule
